msk_shift_loader: RTL and testbench

Masked serial-to-parallel loader placed directly upstream of the enabled masked state registers. It accepts one masked word per handshake, shifts the word into an n-word masked buffer, and presents the whole masked block to the downstream consumer under a valid/ready handshake. Shares are only moved and multiplexed, never combined, so the block can be verified under the same probing model as the rest of the masked datapath. Control (FSM, counter, handshakes) is non-sensitive.

---
 rtl/msk_loader_pkg.sv | 11 +
 rtl/msk_shift_loader_if.sv | 11 +
 rtl/MSKregEn.sv | 14 +
 rtl/msk_loader_ctrl.sv | 46 ++++
 rtl/msk_shift_loader.sv | 36 +++
 tb/tb_msk_shift_loader.sv | 148 ++++++++++++++
 6 files changed

// File: rtl/msk_loader_pkg.sv
// msk_loader_pkg: state encoding and width helper shared by the masked shift loader.
package msk_loader_pkg;
    typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/msk_shift_loader_if.sv
// msk_shift_loader_if: word-in / block-out valid-ready bus of the masked shift loader.
interface msk_shift_loader_if #(parameter int D = 2, parameter int W = 8, parameter int N = 4);
    logic             in_valid;
    logic             in_ready;
    logic [W*D-1:0]   din;
    logic             out_valid;
    logic             out_ready;
    logic [N*W*D-1:0] dout;
    modport master(output in_valid, din, out_ready, input in_ready, out_valid, dout);
    modport slave(input in_valid, din, out_ready, output in_ready, out_valid, dout);
endinterface

// File: rtl/MSKregEn.sv
// MSKregEn: enable-gated masked register; shares are stored side by side and never combined.
module MSKregEn #(parameter int d = 2, parameter int count = 8) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_en,
    input  logic [count*d-1:0]   i_d,
    output logic [count*d-1:0]   o_q
);
    logic [count*d-1:0] r_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_q <= '0;
        else if (i_en) r_q <= i_d;
    assign o_q = r_q;
endmodule

// File: rtl/msk_loader_ctrl.sv
// msk_loader_ctrl: FILL/FULL handshake FSM and word counter; exports acc as the shift enable.
// Optional MSK_LOADER_FLUSH_EN adds i_flush to drop a partial block.
module msk_loader_ctrl import msk_loader_pkg::*; #(parameter int N = 4) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_in_valid,
    input  logic i_out_ready,
`ifdef MSK_LOADER_FLUSH_EN
    input  logic i_flush,
`endif
    output logic o_in_ready,
    output logic o_out_valid,
    output logic o_acc
);
    localparam int CW = clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          w_flush;
`ifdef MSK_LOADER_FLUSH_EN
    assign w_flush = i_flush;
`else
    assign w_flush = 1'b0;
`endif
    // flush only matters while filling; FULL keeps pure consumer backpressure
    assign o_in_ready  = (r_state == FILL) ? ~w_flush : i_out_ready;
    assign o_out_valid = (r_state == FULL);
    assign o_acc       = i_in_valid & o_in_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
            r_cnt   <= '0;
        end else if (r_state == FILL) begin
            if (w_flush) begin
                r_cnt <= '0;
            end else if (o_acc) begin
                r_state <= (r_cnt == LAST) ? FULL : FILL;
                r_cnt   <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
            end
        end else if (i_out_ready) begin
            // a word accepted alongside the transfer starts the next block
            r_state <= (o_acc && N == 1) ? FULL : FILL;
            r_cnt   <= (o_acc && N > 1) ? CW'(1) : '0;
        end
    end
endmodule

// File: rtl/msk_shift_loader.sv
// msk_shift_loader: masked serial-to-parallel loader, one masked word in, n-word masked block out.
// Optional MSK_LOADER_FLUSH_EN adds the flush port.
module msk_shift_loader #(parameter int D = 2, parameter int W = 8, parameter int N = 4) (
    input logic clk,
    input logic rst_n,
`ifdef MSK_LOADER_FLUSH_EN
    input logic flush,
`endif
    msk_shift_loader_if.slave bus
);
    logic                      w_acc;
    logic [N-1:0][W*D-1:0]     w_slot;
    msk_loader_ctrl #(.N(N)) u_ctrl (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_in_valid (bus.in_valid),
        .i_out_ready(bus.out_ready),
`ifdef MSK_LOADER_FLUSH_EN
        .i_flush    (flush),
`endif
        .o_in_ready (bus.in_ready),
        .o_out_valid(bus.out_valid),
        .o_acc      (w_acc)
    );
    // slot k loads slot k+1, the top slot loads din; word 0 ends up in slot 0
    for (genvar k = 0; k < N; k++) begin : g_slot
        if (k == N - 1) begin : g_top
            MSKregEn #(.d(D), .count(W)) u_reg (
                .clk(clk), .rst_n(rst_n), .i_en(w_acc), .i_d(bus.din), .o_q(w_slot[k]));
        end else begin : g_mid
            MSKregEn #(.d(D), .count(W)) u_reg (
                .clk(clk), .rst_n(rst_n), .i_en(w_acc), .i_d(w_slot[k+1]), .o_q(w_slot[k]));
        end
    end
    assign bus.dout = w_slot;
endmodule

// File: tb/tb_msk_shift_loader.sv
// tb_msk_shift_loader: scoreboard bench for msk_shift_loader (d=2, w=8, n=4).
module tb_msk_shift_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int n_checks = 0;
    int n_err = 0;
    int pulses = 0;
    bit mfull = 1'b0;
    logic [15:0] m_words[$];
    logic [63:0] exp_q[$];
    logic [7:0]  vals[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [63:0] held;

    msk_shift_loader_if #(.D(2), .W(8), .N(4)) bus();
    msk_shift_loader #(.D(2), .W(8), .N(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
`ifdef MSK_LOADER_FLUSH_EN
        .flush(flush),
`endif
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mask_word(input logic [7:0] v);
        logic [7:0]  m;
        logic [15:0] r;
        m = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            r[2*i]   = m[i];
            r[2*i+1] = v[i] ^ m[i];
        end
        return r;
    endfunction

    function automatic logic [7:0] unmask(input logic [15:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[2*i] ^ x[2*i+1];
        return r;
    endfunction

    task automatic model_reset();
        m_words.delete();
        mfull = 1'b0;
    endtask

    // called at posedge+1; returns at the following posedge+1
    task automatic step(input bit v, input logic [15:0] w, input bit ordy, input bit fl);
        bit exp_ir, acc, dv, dx;
        logic [63:0] blk;
        bus.in_valid = v;
        bus.din = w;
        bus.out_ready = ordy;
        flush = fl;
        #4;
        exp_ir = mfull ? ordy : !fl;
        check("in_ready", 64'(bus.in_ready), 64'(exp_ir));
        acc = v & exp_ir;
        dv = bus.out_valid;
        dx = dv & ordy;
        @(posedge clk);
        #1;
        if (mfull && ordy) mfull = 1'b0;
        else if (!mfull && fl) m_words.delete();
        if (acc) begin
            m_words.push_back(w);
            if (m_words.size() == 4) begin
                blk = {m_words[3], m_words[2], m_words[1], m_words[0]};
                exp_q.push_back(blk);
                m_words.delete();
                mfull = 1'b1;
            end
        end
        check("out_valid", 64'(bus.out_valid), 64'(mfull));
        if (bus.out_valid && (!dv || dx)) begin
            pulses++;
            check("sb_depth", 64'(exp_q.size()), 64'd1);
            if (exp_q.size() > 0) check("block", bus.dout, exp_q.pop_front());
        end
        bus.in_valid = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        logic [15:0] wd;
        bus.in_valid = 1'b0;
        bus.din = '0;
        bus.out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_dout", bus.dout, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) step(1'b1, mask_word(vals[k]), 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) check("fill_word", 64'(unmask(bus.dout[k*16 +: 16])), 64'(vals[k]));
        held = bus.dout;
        repeat (5) begin
            step(1'b1, mask_word(8'h5A), 1'b0, 1'b0);
            check("bp_dout", bus.dout, held);
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready", 64'(bus.in_ready), 64'd1);
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_dout", bus.dout, 64'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) step(1'b1, mask_word(8'($urandom)), 1'b1, 1'b0);
        check("b2b_pulses", 64'(pulses), 64'd2);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) step(1'b1, mask_word(8'($urandom)), 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 4; k++) step(1'b1, mask_word(8'hA0 + 8'(k)), 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
`ifdef MSK_LOADER_FLUSH_EN
        for (int k = 0; k < 3; k++) step(1'b1, mask_word(8'($urandom)), 1'b0, 1'b0);
        wd = mask_word(8'hEE);
        step(1'b1, wd, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b1, mask_word(8'hC0 + 8'(k)), 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
`else
        wd = '0;
        bus.din = wd;
`endif
        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
